// File: rtl/kgd_fill.sv
// Memory-fill engine: a Wishbone slave register block driving a Wishbone master that
// fills (MODE=0) or inverts in place (MODE=1) a byte range inside a graphics controller.
module kgd_fill (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic [2:0]  m_adr_o,
    output logic [15:0] m_dat_o,
    input  logic [15:0] m_dat_i,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [1:0]  m_sel_o,
    input  logic        m_ack_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_SETA = 3'd1, S_RDAT = 3'd2,
        S_WDAT = 3'd3, S_GAP  = 3'd4, S_FIN  = 3'd5
    } state_t;

    state_t      state_q, state_d, prev_q, prev_d;
    logic [13:0] addr_q, addr_d, rem_q, rem_d;
    logic [7:0]  pat_q, pat_d, cap_q, cap_d;
    logic        mode_q, mode_d, done_q, done_d, abort_q, abort_d;
    logic        ack_q, ack_d;
    logic [15:0] rdat_q, rdat_d;
    logic [2:0]  m_adr_q, m_adr_d;
    logic [15:0] m_dat_q, m_dat_d;
    logic [1:0]  m_sel_q, m_sel_d;
    logic        m_cyc_q, m_cyc_d, m_we_q, m_we_d, busy_q, busy_d;

    logic        busy_s, acc_s, wr_idle_s, go_s, abort_wr_s;
    logic        wr_csr_s, wr_start_s, wr_cnt_s, wr_pat_s;
    logic        unused_s;

    assign busy_s     = (state_q != S_IDLE);
    assign acc_s      = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_idle_s  = acc_s & wb_we_i & ~busy_s;
    assign wr_csr_s   = wr_idle_s & (wb_adr_i[2:1] == 2'b00);
    assign wr_start_s = wr_idle_s & (wb_adr_i[2:1] == 2'b01);
    assign wr_cnt_s   = wr_idle_s & (wb_adr_i[2:1] == 2'b10);
    assign wr_pat_s   = wr_idle_s & (wb_adr_i[2:1] == 2'b11);
    assign go_s       = wr_csr_s & wb_sel_i[0] & wb_dat_i[0];
    assign abort_wr_s = acc_s & wb_we_i & busy_s & (wb_adr_i[2:1] == 2'b00)
                        & wb_sel_i[0] & wb_dat_i[2];
    assign unused_s   = ^{wb_adr_i[0], m_dat_i[15:8]};

    // Slave acknowledge and registered read data
    always_comb begin
        ack_d  = wb_cyc_i & wb_stb_i & ~ack_q;
        rdat_d = 16'h0000;
        if (acc_s && !wb_we_i) begin
            case (wb_adr_i[2:1])
                2'b00:   rdat_d = {busy_s, 7'd0, done_q, 5'd0, mode_q, 1'b0};
                2'b01:   rdat_d = {2'b00, addr_q};
                2'b10:   rdat_d = {2'b00, rem_q};
                2'b11:   rdat_d = {8'h00, pat_q};
                default: rdat_d = 16'h0000;
            endcase
        end else begin
            rdat_d = 16'h0000;
        end
    end

    // START/COUNT double as the working address and remaining count
    always_comb begin
        addr_d  = addr_q;
        rem_d   = rem_q;
        pat_d   = pat_q;
        mode_d  = mode_q;
        done_d  = done_q;
        abort_d = abort_q;
        cap_d   = cap_q;
        if (busy_s) begin
            if (state_q == S_WDAT && m_ack_i) begin
                addr_d = addr_q + 14'd1;
                rem_d  = rem_q - 14'd1;
            end else begin
                addr_d = addr_q;
                rem_d  = rem_q;
            end
            cap_d   = (state_q == S_RDAT && m_ack_i) ? m_dat_i[7:0] : cap_q;
            abort_d = (state_q == S_FIN) ? 1'b0 : (abort_q | abort_wr_s);
            done_d  = done_q | (state_q == S_FIN);
        end else begin
            addr_d[7:0]  = (wr_start_s && wb_sel_i[0]) ? wb_dat_i[7:0]  : addr_q[7:0];
            addr_d[13:8] = (wr_start_s && wb_sel_i[1]) ? wb_dat_i[13:8] : addr_q[13:8];
            rem_d[7:0]   = (wr_cnt_s && wb_sel_i[0])   ? wb_dat_i[7:0]  : rem_q[7:0];
            rem_d[13:8]  = (wr_cnt_s && wb_sel_i[1])   ? wb_dat_i[13:8] : rem_q[13:8];
            pat_d        = (wr_pat_s && wb_sel_i[0])   ? wb_dat_i[7:0]  : pat_q;
            mode_d       = (wr_csr_s && wb_sel_i[0])   ? wb_dat_i[1]    : mode_q;
            done_d       = done_q & ~go_s;
        end
    end

    // FSM next state; prev remembers which master cycle the GAP follows
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        case (state_q)
            S_IDLE: begin
                if (go_s) begin
                    state_d = (rem_q == 14'd0) ? S_FIN : S_SETA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETA, S_RDAT, S_WDAT: begin
                if (m_ack_i) begin
                    state_d = S_GAP;
                    prev_d  = state_q;
                end else begin
                    state_d = state_q;
                end
            end
            S_GAP: begin
                if (abort_d) begin
                    state_d = S_FIN;
                end else begin
                    case (prev_q)
                        S_SETA:  state_d = mode_q ? S_RDAT : S_WDAT;
                        S_RDAT:  state_d = S_WDAT;
                        S_WDAT:  state_d = (rem_q == 14'd0) ? S_FIN : S_SETA;
                        default: state_d = S_FIN;
                    endcase
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Master outputs decoded from the next state so the flops line up with the state
    always_comb begin
        m_cyc_d = 1'b0;
        m_we_d  = 1'b0;
        m_adr_d = 3'b000;
        m_sel_d = 2'b00;
        m_dat_d = 16'h0000;
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_SETA: begin
                m_cyc_d = 1'b1;
                m_we_d  = 1'b1;
                m_adr_d = 3'b100;
                m_sel_d = 2'b11;
                m_dat_d = {2'b00, addr_d};
            end
            S_RDAT: begin
                m_cyc_d = 1'b1;
                m_adr_d = 3'b010;
                m_sel_d = 2'b01;
            end
            S_WDAT: begin
                m_cyc_d = 1'b1;
                m_we_d  = 1'b1;
                m_adr_d = 3'b010;
                m_sel_d = 2'b01;
                m_dat_d = {8'h00, (mode_q ? ~cap_d : pat_q)};
            end
            default: m_cyc_d = 1'b0;
        endcase
    end

    // FSM state register and registered master/busy outputs
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            prev_q  <= S_IDLE;
            m_cyc_q <= 1'b0;
            m_we_q  <= 1'b0;
            m_adr_q <= 3'b000;
            m_sel_q <= 2'b00;
            m_dat_q <= 16'h0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            m_cyc_q <= m_cyc_d;
            m_we_q  <= m_we_d;
            m_adr_q <= m_adr_d;
            m_sel_q <= m_sel_d;
            m_dat_q <= m_dat_d;
            busy_q  <= busy_d;
        end
    end

    // Register file, working counters and slave handshake
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            addr_q  <= 14'd0;
            rem_q   <= 14'd0;
            pat_q   <= 8'h00;
            cap_q   <= 8'h00;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            ack_q   <= 1'b0;
            rdat_q  <= 16'h0000;
        end else begin
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            pat_q   <= pat_d;
            cap_q   <= cap_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = rdat_q;
    assign m_cyc_o  = m_cyc_q;
    assign m_stb_o  = m_cyc_q;
    assign m_we_o   = m_we_q;
    assign m_adr_o  = m_adr_q;
    assign m_sel_o  = m_sel_q;
    assign m_dat_o  = m_dat_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_kgd_fill.sv
// Randomized bench for kgd_fill: a behavioural graphics-controller responder plus a
// transaction-list reference model derived from the fill/invert rules.
module tb_kgd_fill;

    localparam logic [2:0] A_CSR = 3'b000, A_START = 3'b010, A_CNT = 3'b100, A_PAT = 3'b110;

    logic        clk, rst;
    logic [2:0]  wb_adr;
    logic [15:0] wb_dat_w, wb_dat_r;
    logic        wb_cyc, wb_stb, wb_we, wb_ack;
    logic [1:0]  wb_sel;
    logic [2:0]  m_adr_o;
    logic [15:0] m_dat_o, m_dat_i;
    logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i, busy_o;
    logic [1:0]  m_sel_o;

    int checks, errors;
    int dly, wcnt, cyc_seen;
    logic [7:0]  mem [0:16383];
    logic [13:0] ga;
    logic [22:0] snap;
    logic [21:0] log_q[$];
    logic [21:0] exp_q[$];

    kgd_fill dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w),
        .wb_dat_o(wb_dat_r), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_sel_i(wb_sel), .wb_ack_o(wb_ack), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
        .m_dat_i(m_dat_i), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_sel_o(m_sel_o), .m_ack_i(m_ack_i), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Graphics controller model: address register + byte memory, ack after dly wait cycles
    always @(negedge clk) begin
        if (rst) begin
            m_ack_i = 1'b0;
            wcnt    = 0;
        end else if (m_ack_i) begin
            m_ack_i = 1'b0;
            wcnt    = 0;
            chk_eq("gap", 32'({m_cyc_o, m_stb_o}), 32'd0);
        end else if (m_cyc_o) begin
            cyc_seen++;
            if (wcnt == 0) snap = {m_we_o, m_adr_o, m_sel_o, m_dat_o, m_stb_o};
            else chk_eq("stable", 32'({m_we_o, m_adr_o, m_sel_o, m_dat_o, m_stb_o}), 32'(snap));
            if (wcnt >= dly) begin
                log_q.push_back({m_we_o, m_adr_o, m_sel_o, (m_we_o ? m_dat_o : 16'h0000)});
                if (m_we_o && m_adr_o == 3'b100) ga = m_dat_o[13:0];
                else if (m_we_o && m_adr_o == 3'b010) mem[ga] = m_dat_o[7:0];
                else m_dat_i = {8'h5A, mem[ga]};
                m_ack_i = 1'b1;
            end else begin
                wcnt++;
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [2:0] adr, input logic [15:0] dat,
                           input logic [1:0] sel, output logic [15:0] rd);
        int n;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr | 3'($urandom_range(0, 1)); wb_dat_w = dat; wb_sel = sel;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_ack && n < 10);
        if (!wb_ack) chk_eq("wb_ack_timeout", 32'd0, 32'd1);
        rd = wb_dat_r;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] adr, input logic [15:0] dat, input logic [1:0] sel);
        logic [15:0] d;
        wb_xfer(1'b1, adr, dat, sel, d);
    endtask

    task automatic rd(input logic [2:0] adr, output logic [15:0] r);
        wb_xfer(1'b0, adr, 16'h0000, 2'b11, r);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] adr, input logic [15:0] exp);
        logic [15:0] r;
        rd(adr, r);
        chk_eq(tag, 32'(r), 32'(exp));
    endtask

    // Reference: per byte, one address write, an optional read, then the data write
    task automatic build_exp(input logic [13:0] st, input logic [13:0] cnt,
                             input logic [7:0] pat, input logic md, input int limit);
        logic [13:0] a;
        exp_q.delete();
        for (int i = 0; i < int'(cnt) && i < limit; i++) begin
            a = st + 14'(i);
            exp_q.push_back({1'b1, 3'b100, 2'b11, 2'b00, a});
            if (md) exp_q.push_back({1'b0, 3'b010, 2'b01, 16'h0000});
            exp_q.push_back({1'b1, 3'b010, 2'b01, 8'h00, (md ? ~mem[a] : pat)});
        end
    endtask

    task automatic cmp_log();
        chk_eq("log_len", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            chk_eq("log_entry", 32'(log_q[i]), 32'(exp_q[i]));
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy_o && n < max) begin
            @(negedge clk);
            n++;
        end
        chk_eq("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    task automatic run_op(input logic [13:0] st, input logic [13:0] cnt, input logic [7:0] pat,
                          input logic md, input logic meddle);
        wr(A_START, {2'b00, st}, 2'b11);
        wr(A_CNT, {2'b00, cnt}, 2'b11);
        wr(A_PAT, {8'h00, pat}, 2'b11);
        build_exp(st, cnt, pat, md, 100000);
        log_q.delete();
        wr(A_CSR, {14'h0000, md, 1'b1}, 2'b01);
        if (meddle) begin
            wr(A_START, 16'h0000, 2'b11);
            wr(A_CNT, 16'h0000, 2'b11);
            wr(A_PAT, 16'h0011, 2'b11);
            wr(A_CSR, {14'h0000, ~md, 1'b1}, 2'b01);
        end
        wait_idle(20000);
        cmp_log();
        rd_chk("csr_end", A_CSR, {8'h00, 8'h80} | {14'h0000, md, 1'b0});
        rd_chk("start_end", A_START, {2'b00, 14'(st + cnt)});
        rd_chk("count_end", A_CNT, 16'h0000);
        if (meddle) rd_chk("pat_kept", A_PAT, {8'h00, pat});
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; dly = 0; wcnt = 0; cyc_seen = 0; ga = 14'd0;
        m_ack_i = 1'b0; m_dat_i = 16'h0000;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 3'b000;
        wb_dat_w = 16'h0000; wb_sel = 2'b00;
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_eq("rst_master", 32'({m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, m_dat_o}), 32'd0);
        chk_eq("rst_slave", 32'({busy_o, wb_ack, wb_dat_r}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_chk("rst_csr", A_CSR, 16'h0000);
        rd_chk("rst_start", A_START, 16'h0000);
        rd_chk("rst_count", A_CNT, 16'h0000);
        rd_chk("rst_pat", A_PAT, 16'h0000);

        wr(A_CNT, 16'hFFFF, 2'b11);   rd_chk("cnt_mask", A_CNT, 16'h3FFF);
        wr(A_CNT, 16'h1234, 2'b01);   rd_chk("cnt_lo", A_CNT, 16'h3F34);
        wr(A_START, 16'hFFFF, 2'b10); rd_chk("start_hi", A_START, 16'h3F00);
        wr(A_PAT, 16'hABCD, 2'b10);   rd_chk("pat_hi_only", A_PAT, 16'h0000);
        wr(A_PAT, 16'hABCD, 2'b11);   rd_chk("pat_full", A_PAT, 16'h00CD);
        wr(A_CSR, 16'hFFFF, 2'b10);   rd_chk("csr_hi_only", A_CSR, 16'h0000);
        wr(A_CSR, 16'h0006, 2'b01);   rd_chk("csr_mode", A_CSR, 16'h0002);
        chk_eq("abort_idle", 32'(busy_o), 32'd0);
        wr(A_CSR, 16'h0000, 2'b01);   rd_chk("csr_clr", A_CSR, 16'h0000);

        run_op(14'h0010, 14'd3, 8'hA5, 1'b0, 1'b0);
        mem[14'h0100] = 8'h3C;
        run_op(14'h0100, 14'd1, 8'h00, 1'b1, 1'b0);
        chk_eq("invert_mem", 32'(mem[14'h0100]), 32'h0000_00C3);
        run_op(14'h3FFF, 14'd2, 8'h5A, 1'b0, 1'b0);

        // Zero-length operation
        wr(A_CNT, 16'h0000, 2'b11);
        wr(A_CSR, 16'h0000, 2'b01);
        log_q.delete(); cyc_seen = 0;
        wr(A_CSR, 16'h0001, 2'b01);
        n = 0;
        while (busy_o && n < 3) begin @(negedge clk); n++; end
        chk_eq("zero_busy", 32'(busy_o), 32'd0);
        rd_chk("zero_csr", A_CSR, 16'h0080);
        chk_eq("zero_cycles", 32'(cyc_seen), 32'd0);

        dly = 2;
        run_op(14'h1234, 14'd8, 8'h66, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            dly = $urandom_range(0, 3);
            run_op(14'($urandom), 14'($urandom_range(1, 12)), 8'($urandom),
                   1'($urandom_range(0, 1)), 1'b0);
        end

        // Abort during the second data write with slow acks
        dly = 5;
        wr(A_START, 16'h0200, 2'b11);
        wr(A_CNT, 16'd100, 2'b11);
        wr(A_PAT, 16'h0077, 2'b11);
        wr(A_CSR, 16'h0000, 2'b01);
        build_exp(14'h0200, 14'd100, 8'h77, 1'b0, 2);
        log_q.delete();
        wr(A_CSR, 16'h0001, 2'b01);
        n = 0;
        while (!(m_cyc_o && m_adr_o == 3'b010 && log_q.size() == 3) && n < 500) begin
            @(negedge clk); n++;
        end
        chk_eq("abort_reach", 32'(n < 500), 32'd1);
        wr(A_CSR, 16'h0004, 2'b01);
        wait_idle(2000);
        cmp_log();
        rd_chk("abort_count", A_CNT, 16'd98);
        rd_chk("abort_start", A_START, 16'h0202);
        rd_chk("abort_csr", A_CSR, 16'h0080);

        // Reset in the middle of an address write
        wr(A_START, 16'h0300, 2'b11);
        wr(A_CNT, 16'd4, 2'b11);
        wr(A_CSR, 16'h0001, 2'b01);
        n = 0;
        while (!(m_stb_o && m_adr_o == 3'b100) && n < 50) begin @(negedge clk); n++; end
        chk_eq("rst_reach", 32'(m_stb_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_eq("rst_async", 32'({m_cyc_o, m_stb_o, busy_o, m_adr_o, m_dat_o}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc_seen = 0;
        rd_chk("rst2_csr", A_CSR, 16'h0000);
        rd_chk("rst2_start", A_START, 16'h0000);
        rd_chk("rst2_count", A_CNT, 16'h0000);
        rd_chk("rst2_pat", A_PAT, 16'h0000);
        repeat (30) @(negedge clk);
        chk_eq("rst2_quiet", 32'(cyc_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
